// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags decoded
// from a registered occupancy count.
module sync_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] data_out
);

   localparam int          AW         = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wptr;
   logic [AW-1:0]         rptr;
   logic [AW:0]           count;
   logic                  wr_accept;
   logic                  rd_accept;

   assign full      = (count == FULL_COUNT);
   assign empty     = (count == '0);
   assign wr_accept = wr_en & ~full;
   assign rd_accept = rd_en & ~empty;

   // NOTE: storage has no reset so it maps onto plain RAM; stale words are
   // unreachable because the pointers and count are cleared.
   always_ff @(posedge clock) begin
      if (wr_accept) begin
         mem[wptr] <= data_in;
      end
   end

   // NOTE: all state uses non-blocking assignment so every register samples
   // pre-edge values, matching hardware flop behaviour.
   always_ff @(posedge clock) begin
      if (resetn) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         data_out <= '0;
      end else begin
         if (wr_accept) begin
            wptr <= wptr + AW'(1);
         end
         if (rd_accept) begin
            data_out <= mem[rptr];
            rptr     <= rptr + AW'(1);
         end
         case ({wr_accept, rd_accept})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo at DEPTH=1024: a reference model queues
// expected words on writes and a negedge monitor compares flags and data_out.
module tb_sync_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 1024;

   logic          clock = 1'b0;
   logic          resetn;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] data_in;
   logic          full;
   logic          empty;
   logic [DW-1:0] data_out;

   sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clock    (clock),
      .resetn   (resetn),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .data_in  (data_in),
      .full     (full),
      .empty    (empty),
      .data_out (data_out)
   );

   always #5 clock = ~clock;

   int            tests    = 0;
   int            fails    = 0;
   bit            checking = 1'b0;
   logic [DW-1:0] exp_q [$];
   int            model_count = 0;
   logic [DW-1:0] model_dout;
   logic          model_wa;
   logic          model_ra;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: acceptance decided from the model's own occupancy.
   assign model_wa = wr_en && (model_count != DEPTH);
   assign model_ra = rd_en && (model_count != 0);

   always @(posedge clock) begin
      if (resetn) begin
         exp_q.delete();
         model_count <= 0;
         model_dout  <= '0;
         checking    <= 1'b1;
      end else begin
         if (model_wa) exp_q.push_back(data_in);
         if (model_ra) model_dout <= exp_q.pop_front();
         model_count <= model_count + int'(model_wa) - int'(model_ra);
      end
   end

   always @(negedge clock) begin
      if (checking) begin
         check("mon_full",  DW'(full),  DW'(model_count == DEPTH));
         check("mon_empty", DW'(empty), DW'(model_count == 0));
         check("mon_data",  data_out,   model_dout);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic w, input logic r, input logic [DW-1:0] d);
      wr_en   = w;
      rd_en   = r;
      data_in = d;
      step();
      wr_en   = 1'b0;
      rd_en   = 1'b0;
   endtask

   task automatic push(input logic [DW-1:0] d);
      drive(1'b1, 1'b0, d);
   endtask

   task automatic pop();
      drive(1'b0, 1'b1, '0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn  = 1'b1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      data_in = '0;

      // Reset then idle
      repeat (2) step();
      resetn = 1'b0;
      repeat (10) step();
      check("idle_empty", DW'(empty), DW'(1));
      check("idle_full",  DW'(full),  DW'(0));
      check("idle_data",  data_out,   32'h0000_0000);

      // 24 in, 20 out, 4 out
      for (int i = 0; i < 24; i++) push(32'h1000_0000 + DW'(i));
      for (int i = 0; i < 20; i++) pop();
      check("pop20_data", data_out, 32'h1000_0013);
      for (int i = 0; i < 4; i++) pop();
      check("pop24_data",  data_out,   32'h1000_0017);
      check("pop24_empty", DW'(empty), DW'(1));

      // Fill to exactly DEPTH
      for (int i = 0; i < DEPTH-1; i++) push(32'h2000_0000 + DW'(i));
      check("fill1023_full",  DW'(full),  DW'(0));
      check("fill1023_empty", DW'(empty), DW'(0));
      push(32'h2000_03FF);
      check("fill1024_full", DW'(full), DW'(1));
      pop();
      check("first_pop_full", DW'(full), DW'(0));
      check("first_pop_data", data_out,  32'h2000_0000);
      for (int i = 0; i < DEPTH-1; i++) pop();
      check("drain_data",  data_out,   32'h2000_03FF);
      check("drain_empty", DW'(empty), DW'(1));

      // Overflow: 1030 writes, last 6 dropped
      for (int i = 0; i < DEPTH+6; i++) begin
         push(32'h3000_0000 + DW'(i));
         if (i == DEPTH-1) check("ovf_full_at_1024", DW'(full), DW'(1));
      end
      check("ovf_still_full", DW'(full), DW'(1));
      drive(1'b1, 1'b1, 32'hDEAD_BEEF);  // full: read only, write dropped
      check("both_full_data", data_out,  32'h3000_0000);
      check("both_full_flag", DW'(full), DW'(0));
      for (int i = 0; i < DEPTH-1; i++) pop();
      check("ovf_last_data", data_out,   32'h3000_03FF);
      check("ovf_empty",     DW'(empty), DW'(1));

      // Underflow: data_out holds
      for (int i = 0; i < 3; i++) begin
         pop();
         check("udf_hold", data_out,   32'h3000_03FF);
         check("udf_empty", DW'(empty), DW'(1));
      end

      // Simultaneous read/write while empty: write only, no bypass
      drive(1'b1, 1'b1, 32'h4000_0000);
      check("both_empty_nobypass", data_out,   32'h3000_03FF);
      check("both_empty_flag",     DW'(empty), DW'(0));

      // Streaming across 3 pointer wraps with count held at 1
      for (int i = 0; i < 3*DEPTH; i++) drive(1'b1, 1'b1, 32'h4000_0001 + DW'(i));
      check("wrap_data",  data_out,   32'h4000_0BFF);
      check("wrap_empty", DW'(empty), DW'(0));
      check("wrap_full",  DW'(full),  DW'(0));
      pop();
      check("wrap_tail_data",  data_out,   32'h4000_0C00);
      check("wrap_tail_empty", DW'(empty), DW'(1));

      // Mid-operation reset discards contents
      for (int i = 0; i < 50; i++) push(32'h5000_0000 + DW'(i));
      resetn = 1'b1;
      step();
      resetn = 1'b0;
      check("mrst_empty", DW'(empty), DW'(1));
      check("mrst_full",  DW'(full),  DW'(0));
      check("mrst_data",  data_out,   32'h0000_0000);
      push(32'h6000_0001);
      push(32'h6000_0002);
      pop();
      check("mrst_pop1", data_out, 32'h6000_0001);
      pop();
      check("mrst_pop2",  data_out,   32'h6000_0002);
      check("mrst_empty2", DW'(empty), DW'(1));
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
